bcd_seven_seg_scanner: RTL and testbench

Consumes the nine BCD digits produced by the binary-to-BCD converter and drives a time-multiplexed, common-anode seven-segment display. On a load strobe it captures the digits into shadow registers and computes a leading-zero blanking mask. It then scans the digits one at a time, dwelling on each for a fixed number of clock cycles. It sits directly downstream of the converter and directly upstream of the board display pins.

---
 rtl/bcd_seven_seg_scanner.sv | 179 +++++++++++++++++
 tb/tb_bcd_seven_seg_scanner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// bcd_seven_seg_scanner
//
// Purpose:
//   Drives a time-multiplexed, common-anode, nine-digit seven-segment display
//   from the nine BCD digits of the binary-to-BCD converter. A load strobe
//   captures the digits into shadow registers together with a leading-zero
//   blanking mask. From then on the digits are scanned one at a time, with a
//   dwell of PRESCALE clock cycles on each digit.
//
// Parameters:
//   PRESCALE      clock cycles per digit slot (>= 2)
//   CNT_W         prescale counter width (2**CNT_W >= PRESCALE)
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         synchronous active-high reset, overrides load
//   load          one-cycle capture strobe for BCD0..BCD8
//   BCD0..BCD8    BCD digits, BCD0 least significant
//   an[8:0]       anode enables, active low, at most one low
//   seg[6:0]      segments {g,f,e,d,c,b,a}, active low
//   active        high while scanning
//   digit_strobe  one-cycle pulse after the edge that advances the digit
// ---------------------------------------------------------------------------
module bcd_seven_seg_scanner #(
    parameter int PRESCALE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    input  logic [3:0] BCD4,
    input  logic [3:0] BCD5,
    input  logic [3:0] BCD6,
    input  logic [3:0] BCD7,
    input  logic [3:0] BCD8,
    output logic [8:0] an,
    output logic [6:0] seg,
    output logic       active,
    output logic       digit_strobe
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [3:0]       bcd_in [9];
    logic [3:0]       shadow [9];
    logic [8:0]       blank;
    logic [8:0]       blank_next;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       sel;
    logic             wrap;

    assign bcd_in[0] = BCD0;
    assign bcd_in[1] = BCD1;
    assign bcd_in[2] = BCD2;
    assign bcd_in[3] = BCD3;
    assign bcd_in[4] = BCD4;
    assign bcd_in[5] = BCD5;
    assign bcd_in[6] = BCD6;
    assign bcd_in[7] = BCD7;
    assign bcd_in[8] = BCD8;

    // Active-low segment patterns {g..a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Leading-zero mask: walk down from the top digit; a digit is blanked
    // while nothing at or above it is nonzero. Digit 0 always stays lit.
    always_comb begin
        logic seen_nonzero;
        seen_nonzero = 1'b0;
        blank_next   = '0;
        for (int i = 8; i >= 1; i--) begin
            seen_nonzero  = seen_nonzero | (bcd_in[i] != 4'd0);
            blank_next[i] = ~seen_nonzero;
        end
    end

    assign wrap = (state == SCAN) && (cnt == CNT_W'(PRESCALE - 1));

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a load leaves IDLE; SCAN only ends on reset.
    always_comb begin
        next_state = state;
        if (state == IDLE && load) begin
            next_state = SCAN;
        end
    end

    // Moore output.
    always_comb begin
        active = (state == SCAN);
    end

    // Capture path. A load in SCAN replaces the data without touching the
    // scan position, so the display cadence continues uninterrupted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 9; i++) begin
                shadow[i] <= 4'd0;
            end
            blank <= '0;
        end else if (load) begin
            for (int i = 0; i < 9; i++) begin
                shadow[i] <= bcd_in[i];
            end
            blank <= blank_next;
        end
    end

    // Dwell counter and digit select. Both sit at zero outside SCAN, so the
    // scan always starts on digit 0 with a full dwell.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt          <= '0;
            sel          <= 4'd0;
            digit_strobe <= 1'b0;
        end else if (state == SCAN) begin
            digit_strobe <= wrap;
            if (wrap) begin
                cnt <= '0;
                sel <= (sel == 4'd8) ? 4'd0 : sel + 4'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt          <= '0;
            sel          <= 4'd0;
            digit_strobe <= 1'b0;
        end
    end

    // Registered display drive. Computing an and seg together from the
    // current select and shadow gives a single glitch-free update per edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            an  <= 9'h1FF;
            seg <= 7'h7F;
        end else if (state == SCAN && !blank[sel]) begin
            an  <= ~(9'b1 << sel);
            seg <= decode(shadow[sel]);
        end else begin
            an  <= 9'h1FF;
            seg <= 7'h7F;
        end
    end

endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_seven_seg_scanner
//
// Purpose:
//   Drives the scanner with directed and random loads/resets. Each cycle the
//   driver predicts the outputs after the coming edge from a cycle-count view
//   of the scan (digit = elapsed dwell slots mod 9) and queues them; a monitor
//   pops one prediction after every edge and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_bcd_seven_seg_scanner;

    localparam int P = 4;

    typedef struct packed {
        logic [8:0] an;
        logic [6:0] seg;
        logic       active;
        logic       strobe;
    } expect_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ld  = 1'b0;
    logic [8:0][3:0]  din = '0;
    logic [8:0]       an;
    logic [6:0]       seg;
    logic             active;
    logic             digitStrobe;

    expect_t          sbq[$];
    int               errors = 0;
    int               checks = 0;

    int               segTab [16];
    int               cur [9];
    bit               scanning = 0;
    longint           edgeN = 0;
    longint           scanStart = 0;
    int               nextDigit = -1;

    always #5 clk = ~clk;

    bcd_seven_seg_scanner #(.PRESCALE(P), .CNT_W(16)) dut (
        .Clk(clk), .Reset(rst), .load(ld),
        .BCD0(din[0]), .BCD1(din[1]), .BCD2(din[2]), .BCD3(din[3]),
        .BCD4(din[4]), .BCD5(din[5]), .BCD6(din[6]), .BCD7(din[7]),
        .BCD8(din[8]),
        .an(an), .seg(seg), .active(active), .digit_strobe(digitStrobe)
    );

    // Decimal number to BCD digit vector, digit 0 least significant.
    function automatic logic [8:0][3:0] toDigits(input longint v);
        logic [8:0][3:0] d;
        longint          x;
        x = v;
        for (int i = 0; i < 9; i++) begin
            d[i] = 4'(x % 10);
            x = x / 10;
        end
        return d;
    endfunction

    // One clock of stimulus: set inputs, predict the post-edge outputs from
    // the scan position implied by elapsed cycles, then update the model.
    task automatic applyStimulus(input logic r, input logic l, input logic [8:0][3:0] d);
        expect_t e;
        int      top;
        int      dig;
        @(negedge clk);
        rst = r;
        ld  = l;
        din = d;
        edgeN++;
        e.an = 9'h1FF;
        e.seg = 7'h7F;
        e.active = 1'b0;
        e.strobe = 1'b0;
        nextDigit = -1;
        if (!r) begin
            e.active = scanning || l;
            if (scanning) begin
                e.strobe = ((edgeN - scanStart) % P) == 0;
                dig = int'(((edgeN - scanStart - 1) / P) % 9);
                nextDigit = dig;
                top = 0;
                for (int i = 0; i < 9; i++) begin
                    if (cur[i] != 0) top = i;
                end
                if (dig <= top) begin
                    e.an = ~(9'b1 << dig);
                    e.seg = 7'(segTab[cur[dig]]);
                end
            end
        end
        sbq.push_back(e);
        if (r) begin
            scanning = 0;
            for (int i = 0; i < 9; i++) cur[i] = 0;
        end else if (l) begin
            for (int i = 0; i < 9; i++) cur[i] = int'(d[i]);
            if (!scanning) begin
                scanning = 1;
                scanStart = edgeN;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, din);
    endtask

    // Returns 1 when the coming edge is a counter wrap.
    function automatic bit nextIsWrap();
        return scanning && (((edgeN + 1 - scanStart) % P) == 0);
    endfunction

    task automatic checkOutput(input expect_t e);
        checks++;
        if ({an, seg, active, digitStrobe} !== e) begin
            errors++;
            $display("[TB] FAIL outputs @%0t: got an=%h seg=%h active=%b strobe=%b, want an=%h seg=%h active=%b strobe=%b",
                     $time, an, seg, active, digitStrobe, e.an, e.seg, e.active, e.strobe);
        end
    endtask

    // Monitor: every edge yields one output word to check.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) checkOutput(sbq.pop_front());
    end

    initial begin
        logic [8:0][3:0] d;
        int              guard;
        segTab = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                   'h00, 'h10, 'h3F, 'h3F, 'h3F, 'h3F, 'h3F, 'h3F};
        for (int i = 0; i < 9; i++) cur[i] = 0;

        // Reset, then a long idle stretch with changing but unloaded inputs.
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, toDigits($urandom_range(0, 999999999)));

        // Full-width number with an internal zero, two complete scans.
        applyStimulus(1'b0, 1'b1, toDigits(650345768));
        idleCycles(9 * P * 2 + 3);

        // Leading zeros blanked.
        applyStimulus(1'b0, 1'b1, toDigits(1234593));
        idleCycles(9 * P + 5);

        // All zeros: only digit 0 lit.
        applyStimulus(1'b0, 1'b1, '0);
        idleCycles(9 * P + 2);

        // Non-BCD code, then a reload landing on a wrap edge.
        d = toDigits(987654321);
        d[3] = 4'hC;
        applyStimulus(1'b0, 1'b1, d);
        idleCycles(9 * P + 1);
        guard = 0;
        while (!nextIsWrap() && guard < 10) begin
            idleCycles(1);
            guard++;
        end
        d[3] = 4'h9;
        applyStimulus(1'b0, 1'b1, d);
        idleCycles(9 * P + 4);

        // Reset coinciding with a load while digit 4 is on the display.
        guard = 0;
        while (nextDigit != 4 && guard < 9 * P + 2) begin
            idleCycles(1);
            guard++;
        end
        applyStimulus(1'b1, 1'b1, toDigits(111111111));
        idleCycles(6);
        applyStimulus(1'b0, 1'b1, toDigits(24680));
        idleCycles(9 * P + 2);

        // Random loads (with random leading zeros) and occasional resets.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                applyStimulus(1'b1, $urandom_range(0, 1) == 1, din);
            end else if (r < 14) begin
                d = '0;
                for (int k = 0; k < int'($urandom_range(0, 9)); k++) d[k] = 4'($urandom_range(0, 15));
                applyStimulus(1'b0, 1'b1, d);
            end else begin
                applyStimulus(1'b0, 1'b0, toDigits($urandom_range(0, 999999)));
            end
        end

        applyStimulus(1'b0, 1'b0, din);
        @(posedge clk);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
